regfile_mp: RTL

Parametrised multi-port integer register file for the AKARIN RISC-V core, successor to the single-write/dual-read file in the decode stage. Provides NRD registered read ports and NWR write ports with configurable data width and register count, and a hardwired zero register. A post-reset clearing sequencer zeroes the array before the pipeline may use it, and an optional write-to-read bypass resolves same-cycle read-after-write hazards.

---
 rtl/regfile_mp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port integer register file for the AKARIN RISC-V core.
//
// NRD registered read ports and NWR write ports over NREG registers of XLEN
// bits. Register x0 is hardwired to zero and is never written. After reset a
// clearing sequencer zeroes x1..x(NREG-1), one register per cycle. Reads and
// writes are accepted only once ready_o is high.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - a read of a register written at the same edge returns the
//               write data; the highest-index matching write port wins.
//   undefined - reads return the contents before the edge (read-before-write).
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst       asynchronous active-high reset
//   rdEn_i    [NRD]       per-port read enable
//   rdAddr_i  [NRD*AW]    read address, port k at [k*AW +: AW]
//   rdData_o  [NRD*XLEN]  registered read data, port k at [k*XLEN +: XLEN]
//   wrEn_i    [NWR]       per-port write enable
//   wrAddr_i  [NWR*AW]    write address, port k at [k*AW +: AW]
//   wrData_i  [NWR*XLEN]  write data, port k at [k*XLEN +: XLEN]
//   ready_o               high once clearing has completed
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rdEn_i,
    input  logic [NRD*AW-1:0]   rdAddr_i,
    output logic [NRD*XLEN-1:0] rdData_o,
    input  logic [NWR-1:0]      wrEn_i,
    input  logic [NWR*AW-1:0]   wrAddr_i,
    input  logic [NWR*XLEN-1:0] wrData_i,
    output logic                ready_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic            clr_we;
    logic            run;

    // Entry 0 exists only to keep indexing simple; it is never written and
    // never returned, because address 0 is decoded to a constant zero.
    logic [XLEN-1:0] rf [NREG];

    logic [XLEN-1:0] rd_next [NRD];
    logic [NRD*XLEN-1:0] rd_data_p1;

    // ---------------------------------------------------------------------
    // Control: clearing sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RUN;
                end else begin
                    clr_idx_d = clr_idx_q + AW'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign run     = (state_q == RUN);
    assign ready_o = run;

    // ---------------------------------------------------------------------
    // Storage: clearing writes, then port writes (later ports override)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_we) begin
            rf[clr_idx_q] <= '0;
        end else if (run) begin
            for (int w = 0; w < NWR; w++) begin
                if (wrEn_i[w] && (wrAddr_i[w*AW +: AW] != '0)) begin
                    rf[wrAddr_i[w*AW +: AW]] <= wrData_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read select (stage 0): array lookup, optional same-edge forwarding
    // ---------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_next[k] = '0;
            if (rdAddr_i[k*AW +: AW] != '0) begin
                rd_next[k] = rf[rdAddr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Ascending scan so the highest-index matching writer wins,
                // matching the storage priority.
                for (int w = 0; w < NWR; w++) begin
                    if (wrEn_i[w] && (wrAddr_i[w*AW +: AW] == rdAddr_i[k*AW +: AW])) begin
                        rd_next[k] = wrData_i[w*XLEN +: XLEN];
                    end
                end
`endif
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read register (stage 1): holds its value while the port is idle
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_p1 <= '0;
        end else if (run) begin
            for (int k = 0; k < NRD; k++) begin
                if (rdEn_i[k]) begin
                    rd_data_p1[k*XLEN +: XLEN] <= rd_next[k];
                end
            end
        end
    end

    assign rdData_o = rd_data_p1;

endmodule
